blink_round_key_sched: RTL and testbench

- Iterative key schedule for the Blink_64a datapath.
- Expands a 128-bit master key into ROUNDS 64-bit round keys, one per accepted transfer.
- Sits directly upstream of the column-mix/add-key stage, which consumes `rk_out` as its 64-bit `key` operand.
- Delivery uses a valid/ready handshake, so the round controller can stall the schedule.

---
 rtl/blink_round_key_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_blink_round_key_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/blink_round_key_sched.sv
// Iterative key schedule for Blink_64a: a 128-bit master key expands into ROUNDS 64-bit round keys.
// Defining BLINK_KS_OUTREG_EN inserts a 2-entry skid buffer between the generator and the outputs.
module blink_round_key_sched #(
  parameter int ROUNDS = 16,
  parameter int RC_LSB = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [63:0]  rk_out,
  output logic [4:0]   rk_index,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Rotate left by 61, substitute the top nibble, then fold in the round constant r+1.
  function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [4:0] r);
    logic [127:0] t;
    t = {k[66:0], k[127:67]};
    t[127:124] = sbox(t[127:124]);
    t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ (r + 5'd1);
    return t;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] k_q, k_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         gen_adv_s;
  logic         drain_done_s;

`ifdef BLINK_KS_OUTREG_EN
  // The generator only looks at the registered skid flag, keeping rk_ready out of the K update path.
  localparam state_e LAST_STATE = ST_DRAIN;

  logic        out_valid_q, out_valid_d;
  logic [63:0] out_key_q, out_key_d;
  logic [4:0]  out_idx_q, out_idx_d;
  logic        skid_valid_q, skid_valid_d;
  logic [63:0] skid_key_q, skid_key_d;
  logic [4:0]  skid_idx_q, skid_idx_d;
  logic        pop_s;

  assign pop_s        = out_valid_q & rk_ready;
  assign gen_adv_s    = (state_q == ST_GEN) & ~skid_valid_q;
  assign drain_done_s = pop_s & ~skid_valid_q;

  // Skid buffer next-state: refill the output slot from skid first, else from the generator.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_key_d    = out_key_q;
    out_idx_d    = out_idx_q;
    skid_valid_d = skid_valid_q;
    skid_key_d   = skid_key_q;
    skid_idx_d   = skid_idx_q;
    if (!out_valid_q || pop_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_key_d    = skid_key_q;
        out_idx_d    = skid_idx_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = gen_adv_s;
        if (gen_adv_s) begin
          out_key_d = k_q[63:0];
          out_idx_d = cnt_q;
        end else begin
          out_key_d = out_key_q;
        end
      end
    end else begin
      if (gen_adv_s) begin
        skid_valid_d = 1'b1;
        skid_key_d   = k_q[63:0];
        skid_idx_d   = cnt_q;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Skid buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_key_q    <= 64'd0;
      out_idx_q    <= 5'd0;
      skid_valid_q <= 1'b0;
      skid_key_q   <= 64'd0;
      skid_idx_q   <= 5'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_key_q    <= out_key_d;
      out_idx_q    <= out_idx_d;
      skid_valid_q <= skid_valid_d;
      skid_key_q   <= skid_key_d;
      skid_idx_q   <= skid_idx_d;
    end
  end

  assign rk_out   = out_key_q;
  assign rk_index = out_idx_q;
  assign rk_valid = out_valid_q;
`else
  localparam state_e LAST_STATE = ST_DONE;

  logic valid_q, valid_d;

  assign gen_adv_s    = (state_q == ST_GEN) & rk_ready;
  assign drain_done_s = 1'b0;

  // Valid flag tracks the GEN state one-for-one.
  always_comb begin
    valid_d = (state_d == ST_GEN);
  end

  // Valid register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rk_out   = k_q[63:0];
  assign rk_index = cnt_q;
  assign rk_valid = valid_q;
`endif

  // Generator FSM next-state and key state update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = key_in;
          cnt_d   = 5'd0;
          state_d = ST_GEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (gen_adv_s) begin
          if (cnt_q == LAST_IDX) begin
            state_d = LAST_STATE;
          end else begin
            k_d   = ks_step(k_q, cnt_q);
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          state_d = ST_GEN;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_GEN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // Generator state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= 128'd0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_blink_round_key_sched.sv
// Directed self-checking bench for blink_round_key_sched (ROUNDS=16 plus a ROUNDS=1 instance).
module tb_blink_round_key_sched;

  localparam int ROUNDS = 16;
`ifdef BLINK_KS_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [3:0] SBOX_TBL [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = 128'd0;
  logic         rk_ready = 1'b0;
  logic [63:0]  rk_out, r1_out;
  logic [4:0]   rk_index, r1_index;
  logic         rk_valid, busy, done;
  logic         r1_valid, r1_busy, r1_done;

  int checks = 0;
  int errors = 0;
  logic [63:0] cur_seq [ROUNDS];
  logic [63:0] ref_seq [ROUNDS];

  blink_round_key_sched #(.ROUNDS(ROUNDS), .RC_LSB(15)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .rk_out(rk_out), .rk_index(rk_index), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .busy(busy), .done(done)
  );

  blink_round_key_sched #(.ROUNDS(1), .RC_LSB(15)) u_dut_r1 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .rk_out(r1_out), .rk_index(r1_index), .rk_valid(r1_valid), .rk_ready(rk_ready),
    .busy(r1_busy), .done(r1_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference update: bitwise rotate, table S-box, constant r+1 at bits [19:15].
  function automatic logic [127:0] ref_step(input logic [127:0] k, input int r);
    logic [127:0] t;
    for (int i = 0; i < 128; i++) t[(i + 61) % 128] = k[i];
    t[127:124] = SBOX_TBL[t[127:124]];
    for (int b = 0; b < 5; b++) begin
      if ((((r + 1) >> b) & 1) != 0) t[15 + b] = ~t[15 + b];
    end
    return t;
  endfunction

  // mode 0: always ready; 1: ready 1,0,0 repeating; 2: stray start mid-GEN; 3: reset at index 5
  task automatic run_seq(input string tag, input logic [127:0] key, input int mode,
                         input logic [127:0] alt_key);
    logic [127:0] mk;
    logic [63:0]  prev_out;
    logic [4:0]   prev_idx;
    logic         prev_stall, rdy;
    int idx, last_acc, first_v, done_cnt, done_cyc, ph;
    bit aborted;
    mk = key; idx = 0; last_acc = -100; first_v = -1; done_cnt = 0; done_cyc = -1;
    ph = 0; prev_stall = 1'b0; prev_out = 64'd0; prev_idx = 5'd0; aborted = 1'b0;
    @(negedge clk); key_in = key; start = 1'b1; rk_ready = 1'b0;
    @(negedge clk); start = 1'b0; key_in = ~key;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rk_valid) begin
        if (first_v < 0) first_v = cyc;
        if (prev_stall) begin
          check_val({tag, "_hold_key"}, rk_out, prev_out);
          check_val({tag, "_hold_idx"}, rk_index, prev_idx);
        end
        if (idx < ROUNDS) begin
          check_val({tag, "_idx"}, rk_index, idx);
          check_val({tag, "_key"}, rk_out, mk[63:0]);
          cur_seq[idx] = rk_out;
        end
      end
      if (mode == 3 && rk_valid && rk_index == 5'd5) begin
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_val({tag, "_rst_valid"}, rk_valid, 1'b0);
        check_val({tag, "_rst_busy"}, busy, 1'b0);
        check_val({tag, "_rst_done"}, done, 1'b0);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check_val({tag, "_rst_quiet"}, {rk_valid, done}, 2'b00);
        end
        aborted = 1'b1;
        break;
      end
      if (mode == 2 && cyc == 3) begin start = 1'b1; key_in = alt_key; end
      else start = 1'b0;
      rdy = (mode == 1) ? (ph == 0) : 1'b1;
      ph = (ph + 1) % 3;
      rk_ready = rdy;
      if (rk_valid && rdy) begin
        if (idx < ROUNDS - 1) mk = ref_step(mk, idx);
        idx++;
        last_acc = cyc;
      end
      prev_stall = rk_valid && !rdy;
      prev_out = rk_out;
      prev_idx = rk_index;
      if (idx >= ROUNDS && cyc >= last_acc + 3) break;
    end
    start = 1'b0;
    rk_ready = 1'b0;
    if (mode == 3) begin
      check_val({tag, "_aborted"}, aborted, 1'b1);
      check_val({tag, "_abort_done"}, done_cnt, 0);
    end else begin
      check_val({tag, "_count"}, idx, ROUNDS);
      check_val({tag, "_first_lat"}, first_v, LAT);
      check_val({tag, "_done_cnt"}, done_cnt, 1);
      check_val({tag, "_done_cyc"}, done_cyc, last_acc + 1);
      if (mode != 1) check_val({tag, "_full_rate"}, last_acc, first_v + ROUNDS - 1);
    end
  endtask

  initial begin
    logic [127:0] k1;
    int v1, d1;
    logic [63:0] r1_key;
    k1 = {64'h0123456789abcdef, 64'hfedcba9876543210};

    // Reset and idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("rst_out", {rk_out, rk_index, rk_valid, busy, done}, 72'd0);
    rk_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_val("idle_valid", {rk_valid, rk_index, busy}, 7'd0);
    end
    rk_ready = 1'b0;

    // Zero key, full rate, hand-computed first keys
    run_seq("zero", 128'd0, 0, 128'd0);
    check_val("zero_k0", cur_seq[0], 64'h0000000000000000);
    check_val("zero_k1", cur_seq[1], 64'h0000000000008000);
    check_val("zero_k2", cur_seq[2], 64'h1800000000010000);

    // Nonzero key, full rate, then with back-pressure
    run_seq("k1", k1, 0, 128'd0);
    check_val("k1_k0", cur_seq[0], 64'hfedcba9876543210);
    check_val("k1_k1", cur_seq[1], 64'h002468acf135f9bd);
    for (int i = 0; i < ROUNDS; i++) ref_seq[i] = cur_seq[i];
    run_seq("bp", k1, 1, 128'd0);
    for (int i = 0; i < ROUNDS; i++) check_val("bp_vs_ready", cur_seq[i], ref_seq[i]);

    // Stray start during GEN
    run_seq("start_gen", k1, 2, {64'h1111111111111111, 64'h2222222222222222});
    check_val("start_gen_last", cur_seq[ROUNDS - 1], ref_seq[ROUNDS - 1]);

    // Reset mid-sequence, then a fresh start
    run_seq("abort", k1, 3, 128'd0);
    run_seq("restart", {64'hdeadbeefcafef00d, 64'h0f1e2d3c4b5a6978}, 0, 128'd0);
    check_val("restart_k0", cur_seq[0], 64'h0f1e2d3c4b5a6978);

    // ROUNDS=1 instance: one key, no update, one done pulse
    v1 = 0; d1 = 0; r1_key = 64'd0;
    @(negedge clk); key_in = {64'haaaa5555aaaa5555, 64'h0123012301230123}; start = 1'b1;
    @(negedge clk); start = 1'b0; rk_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (r1_valid) begin v1++; r1_key = r1_out; check_val("r1_idx", r1_index, 5'd0); end
      if (r1_done) d1++;
      @(negedge clk);
    end
    check_val("r1_valid_cnt", v1, 1);
    check_val("r1_done_cnt", d1, 1);
    check_val("r1_key", r1_key, 64'h0123012301230123);
    for (int c = 0; c < 60; c++) begin
      if (!busy && !rk_valid && !done) break;
      @(negedge clk);
    end
    check_val("final_idle", {busy, rk_valid}, 2'b00);
    rk_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
